// File: rtl/program_mem_arbiter.sv
// program_mem_arbiter: shares a single program-memory read port among
// NUM_CONSUMERS instruction fetchers, one outstanding read at a time, and
// relays each response back over a four-phase valid/ready handshake.
//
// Optional feature macro: PROGRAM_MEM_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin winner selection starting after the last grant
//   undefined -> fixed priority, lowest requesting index wins
//
// state         | meaning
// --------------+--------------------------------------------------------
// IDLE          | no grant outstanding; looking for a requester
// READ_WAITING  | request presented to memory, waiting for mem_read_ready
// READ_RELAYING | data on winner's lane, ready held until its valid drops
module program_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 32,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int ID_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE          = 2'b00,
    READ_WAITING  = 2'b01,
    READ_RELAYING = 2'b10
  } state_t;

  state_t                   state_q, state_d;
  logic [ID_BITS-1:0]       grant_id_q, grant_id_d;
  logic                     mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]     mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0] ready_q, ready_d;
  logic [DATA_BITS-1:0]     data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     data_d [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     lane_addr [NUM_CONSUMERS];

  logic                     any_req;
  logic [ID_BITS-1:0]       winner;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_lane
      assign lane_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = data_q[gi];
    end
  endgenerate

  assign consumer_read_ready = ready_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;

`ifdef PROGRAM_MEM_ARBITER_ROUND_ROBIN_EN
  localparam logic [ID_BITS:0] NUM_W = (ID_BITS+1)'(NUM_CONSUMERS);

  logic [ID_BITS-1:0] last_grant_q, last_grant_d;
  logic [ID_BITS:0]   cand;

  // Round-robin search: first requester at or after last_grant+1, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = {1'b0, last_grant_q} + (ID_BITS+1)'(i + 1);
      if (cand >= NUM_W) cand = cand - NUM_W;
      if (!any_req && consumer_read_valid[cand[ID_BITS-1:0]]) begin
        any_req = 1'b1;
        winner  = cand[ID_BITS-1:0];
      end
    end
  end

  // Remember the previous winner so the next search starts just past it.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= ID_BITS'(NUM_CONSUMERS - 1);
    else       last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: scanning downward leaves the lowest requester selected.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
      if (consumer_read_valid[i]) begin
        any_req = 1'b1;
        winner  = ID_BITS'(i);
      end
    end
  end
`endif

  // Next-state and registered-output decode for the grant/relay sequence.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    ready_d     = ready_q;
    data_d      = data_q;
`ifdef PROGRAM_MEM_ARBITER_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d  = winner;
          mem_addr_d  = lane_addr[winner];
          mem_valid_d = 1'b1;
          state_d     = READ_WAITING;
`ifdef PROGRAM_MEM_ARBITER_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
        end
      end
      READ_WAITING: begin
        // The fetcher's address is latched at grant; later edits are ignored.
        if (mem_read_ready) begin
          mem_valid_d         = 1'b0;
          data_d[grant_id_q]  = mem_read_data;
          ready_d[grant_id_q] = 1'b1;
          state_d             = READ_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant_id_q]) begin
          ready_d[grant_id_q] = 1'b0;
          state_d             = IDLE;
        end
      end
      default: begin
        // Unused encoding: recover to a clean idle with nothing asserted.
        mem_valid_d = 1'b0;
        ready_d     = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Self-checking bench for program_mem_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_program_mem_arbiter;
  localparam int AB = 8;
  localparam int DB = 32;
  localparam int N  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      crv;
  logic [N*AB-1:0]   cra;
  logic [N-1:0]      crr;
  logic [N*DB-1:0]   crd;
  logic              mrv;
  logic [AB-1:0]     mra;
  logic              mrr;
  logic [DB-1:0]     mrd;

  always #5 clk = ~clk;

  program_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (crv),
    .consumer_read_address (cra),
    .consumer_read_ready   (crr),
    .consumer_read_data    (crd),
    .mem_read_valid        (mrv),
    .mem_read_address      (mra),
    .mem_read_ready        (mrr),
    .mem_read_data         (mrd)
  );

  int total = 0;
  int bad   = 0;

  logic [AB-1:0] addr   [N];
  logic [DB-1:0] m_data [N];
  int            m_last;

  always_comb begin
    cra = '0;
    for (int i = 0; i < N; i++) cra[i*AB +: AB] = addr[i];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DB-1:0] exp_data();
    logic [N*DB-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DB +: DB] = m_data[i];
    return v;
  endfunction

  // Which requester should win, given the request mask and previous winner.
  function automatic int pick(input logic [N-1:0] m, input int last);
`ifdef PROGRAM_MEM_ARBITER_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
`else
    for (int c = 0; c < N; c++) if (m[c]) return c;
`endif
    return 0;
  endfunction

  task automatic model_reset;
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_data[i] = '0;
  endtask

  // One full read: grant, memory wait of lat cycles, relay, release.
  task automatic txn(input logic [N-1:0] mask, input int lat, input logic [DB-1:0] d,
                     input bit chg, input bit viol);
    int g;
    int n;
    logic [AB-1:0] a;
    g = pick(mask, m_last);
    a = addr[g];
    crv = mask;
    n = 0;
    do begin
      tick;
      n++;
    end while (!mrv && n < 8);
    chk("grant_lat", n, 1);
    if (!mrv) return;
    chk("mem_addr", mra, a);
    chk("grant_no_ready", crr, 0);
    if (viol) crv[g] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (chg) addr[g] = addr[g] + 8'd2;
      tick;
      chk("wait_valid", mrv, 1);
      chk("wait_addr", mra, a);
      chk("wait_ready", crr, 0);
    end
    mrr = 1'b1;
    mrd = d;
    tick;
    mrr = 1'b0;
    mrd = $urandom;
    m_data[g] = d;
    m_last    = g;
    chk("relay_ready", crr, N'(1) << g);
    chk("relay_data", crd, exp_data());
    chk("relay_memv", mrv, 0);
    if (viol) begin
      tick;
      chk("viol_drop", crr, 0);
    end else begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        tick;
        chk("relay_hold", crr, N'(1) << g);
      end
      crv[g] = 1'b0;
      tick;
      chk("ready_drop", crr, 0);
      chk("idle_memv", mrv, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    crv   = '0;
    mrr   = 1'b0;
    mrd   = '0;
    for (int i = 0; i < N; i++) addr[i] = '0;
    model_reset();
    tick;
    tick;
    chk("rst_memv", mrv, 0);
    chk("rst_addr", mra, 0);
    chk("rst_ready", crr, 0);
    chk("rst_data", crd, 0);
    reset = 1'b0;

    // Stray memory response while idle.
    mrr = 1'b1;
    mrd = 32'h12345678;
    tick;
    mrr = 1'b0;
    tick;
    chk("stray_ready", crr, 0);
    chk("stray_memv", mrv, 0);
    chk("stray_data", crd, exp_data());

    // Single request from consumer 2.
    addr[2] = 8'h1A;
    txn(4'b0100, 3, 32'hDEADBEEF, 1'b0, 1'b0);

    // All consumers requesting continuously.
    for (int i = 0; i < N; i++) addr[i] = 8'h40 + 8'(i);
    for (int t = 0; t < 5; t++) txn(4'hF, $urandom_range(0, 3), $urandom, 1'b0, 1'b0);

    // Long memory stall.
    addr[3] = 8'h9C;
    txn(4'b1000, 20, 32'hCAFEF00D, 1'b0, 1'b0);

    // Address edited while waiting.
    addr[1] = 8'h05;
    txn(4'b0010, 3, 32'h0BADC0DE, 1'b1, 1'b0);

    // Granted consumer drops valid while waiting.
    addr[0] = 8'h77;
    txn(4'b0001, 2, 32'h55AA55AA, 1'b0, 1'b1);

    // Reset while a read is outstanding; a late response must be dropped.
    addr[2] = 8'h33;
    crv = 4'b0100;
    tick;
    chk("midrst_granted", mrv, 1);
    reset = 1'b1;
    crv   = '0;
    tick;
    reset = 1'b0;
    model_reset();
    chk("midrst_memv", mrv, 0);
    chk("midrst_addr", mra, 0);
    chk("midrst_ready", crr, 0);
    chk("midrst_data", crd, 0);
    mrr = 1'b1;
    tick;
    mrr = 1'b0;
    tick;
    chk("midrst_no_relay", crr, 0);
    chk("midrst_idle", mrv, 0);
    addr[0] = 8'h11;
    txn(4'hF, 1, 32'h01020304, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) addr[i] = AB'($urandom);
      txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 4), $urandom,
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
